// File: rtl/ring_buffer_checker.sv
// ring_buffer_checker: shadows each strobed burst written into the DDR read-data
// ring buffer and checks every read-pointer change against the shadow copy.
// Mismatches are counted and the first one is captured for later inspection.
module ring_buffer_checker #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned PTR_W    = $clog2(DEPTH),
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DDR_MODE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              listen,
   input  logic              strobe,
   input  logic [DATA_W-1:0] din,
   input  logic [PTR_W-1:0]  readPtr,
   input  logic [DATA_W-1:0] dout,
   output logic              shadow_valid,
   output logic              burst_done,
   output logic              abort,
   output logic              mismatch,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  burst_count,
   output logic              first_err_valid,
   output logic [PTR_W-1:0]  first_err_ptr,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_act
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_FULL    = 2'd3;

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // state and capture bookkeeping
   logic [1:0]        r_state;
   logic [PTR_W-1:0]  r_idx;
   logic              r_strobe_q;
   logic              r_shadow_valid;
   logic              r_burst_done;
   logic              r_abort;

   // shadow copy of the ring contents (no reset: contents are don't-care)
   logic [DATA_W-1:0] r_shadow [DEPTH];

   // read compare pipeline
   logic [PTR_W-1:0]  r_ptr_q;
   logic              r_cmp_pend;
   logic [PTR_W-1:0]  r_cmp_ptr;
   logic              r_mismatch;

   // status counters and first-error capture
   logic [CNT_W-1:0]  r_err_count;
   logic [CNT_W-1:0]  r_burst_count;
   logic              r_first_err_valid;
   logic [PTR_W-1:0]  r_first_err_ptr;
   logic [DATA_W-1:0] r_first_err_exp;
   logic [DATA_W-1:0] r_first_err_act;

   // combinational control
   logic              w_beat;
   logic [1:0]        w_state_nx;
   logic [PTR_W-1:0]  w_idx_nx;
   logic              w_sv_nx;
   logic              w_wr_en;
   logic [PTR_W-1:0]  w_wr_idx;
   logic              w_burst_fin;
   logic              w_abort;
   logic              w_ptr_chg;
   logic [DATA_W-1:0] w_exp;
   logic              w_miss;

   // beat detect: every strobe edge in DDR mode, rising edge only in SDR mode
   always_comb begin
      w_beat = 1'b0;
      if (DDR_MODE != 0) begin
         w_beat = strobe ^ r_strobe_q;
      end else begin
         w_beat = strobe & ~r_strobe_q;
      end
   end

   // next-state and capture control; abort has priority over a same-cycle beat
   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      w_sv_nx     = r_shadow_valid;
      w_wr_en     = 1'b0;
      w_wr_idx    = '0;
      w_burst_fin = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (listen) begin
               w_state_nx = S_ARMED;
            end
         end
         S_ARMED: begin
            if (!listen) begin
               w_state_nx = S_IDLE;
            end else if (w_beat) begin
               w_wr_en    = 1'b1;
               w_wr_idx   = '0;
               w_idx_nx   = PTR_W'(1);
               w_state_nx = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (!listen) begin
               w_abort    = 1'b1;
               w_sv_nx    = 1'b0;
               w_idx_nx   = '0;
               w_state_nx = S_IDLE;
            end else if (w_beat) begin
               w_wr_en  = 1'b1;
               w_wr_idx = r_idx;
               if (r_idx == LAST_IDX) begin
                  w_burst_fin = 1'b1;
                  w_sv_nx     = 1'b1;
                  w_idx_nx    = '0;
                  w_state_nx  = S_FULL;
               end else begin
                  w_idx_nx = r_idx + PTR_W'(1);
               end
            end
         end
         S_FULL: begin
            // shadow is retained while listen is low; a new armed beat starts over
            if (listen && w_beat) begin
               w_wr_en    = 1'b1;
               w_wr_idx   = '0;
               w_idx_nx   = PTR_W'(1);
               w_sv_nx    = 1'b0;
               w_state_nx = S_CAPTURE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
            w_sv_nx    = 1'b0;
         end
      endcase
   end

   // compare path: a pending compare reads the shadow before any same-cycle write
   always_comb begin
      w_ptr_chg = (readPtr != r_ptr_q) && r_shadow_valid;
      w_exp     = r_shadow[r_cmp_ptr];
      w_miss    = r_cmp_pend && (dout != w_exp);
   end

   // FSM state, beat index, strobe history and capture pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_strobe_q     <= 1'b0;
         r_shadow_valid <= 1'b0;
         r_burst_done   <= 1'b0;
         r_abort        <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_idx          <= w_idx_nx;
         r_strobe_q     <= strobe;
         r_shadow_valid <= w_sv_nx;
         r_burst_done   <= w_burst_fin;
         r_abort        <= w_abort;
      end
   end

   // shadow storage write
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_shadow[w_wr_idx] <= din;
      end
   end

   // pointer history and one-deep compare pipeline
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr_q    <= '0;
         r_cmp_pend <= 1'b0;
         r_cmp_ptr  <= '0;
         r_mismatch <= 1'b0;
      end else begin
         r_ptr_q    <= readPtr;
         r_cmp_pend <= w_ptr_chg;
         if (w_ptr_chg) begin
            r_cmp_ptr <= readPtr;
         end
         r_mismatch <= w_miss;
      end
   end

   // saturating counters and first-error capture; clear beats a coincident event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_count       <= '0;
         r_burst_count     <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_ptr   <= '0;
         r_first_err_exp   <= '0;
         r_first_err_act   <= '0;
      end else if (clear) begin
         r_err_count       <= '0;
         r_burst_count     <= '0;
         r_first_err_valid <= 1'b0;
         r_first_err_ptr   <= '0;
         r_first_err_exp   <= '0;
         r_first_err_act   <= '0;
      end else begin
         if (w_miss && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
         end
         if (w_burst_fin && (r_burst_count != CNT_MAX)) begin
            r_burst_count <= r_burst_count + CNT_W'(1);
         end
         if (w_miss && !r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_ptr   <= r_cmp_ptr;
            r_first_err_exp   <= w_exp;
            r_first_err_act   <= dout;
         end
      end
   end

   assign shadow_valid    = r_shadow_valid;
   assign burst_done      = r_burst_done;
   assign abort           = r_abort;
   assign mismatch        = r_mismatch;
   assign err_count       = r_err_count;
   assign burst_count     = r_burst_count;
   assign first_err_valid = r_first_err_valid;
   assign first_err_ptr   = r_first_err_ptr;
   assign first_err_exp   = r_first_err_exp;
   assign first_err_act   = r_first_err_act;

endmodule

// File: tb/tb_ring_buffer_checker.sv
// tb_ring_buffer_checker: directed bench for ring_buffer_checker.
// u_a: DDR, DEPTH 8, 16-bit counters; u_b: same stimulus with 4-bit counters;
// u_c: SDR, DEPTH 4 with its own capture inputs.
module tb_ring_buffer_checker;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        listen;
   logic        strobe;
   logic [15:0] din;
   logic [2:0]  rd_ptr;
   logic [15:0] dout;

   logic        c_listen;
   logic        c_strobe;
   logic [15:0] c_din;
   logic [1:0]  c_ptr;

   logic        a_sv, a_done, a_abort, a_miss, a_fev;
   logic [15:0] a_err, a_bcnt, a_fexp, a_fact;
   logic [2:0]  a_fptr;

   logic        b_sv, b_done, b_abort, b_miss, b_fev;
   logic [3:0]  b_err, b_bcnt;
   logic [15:0] b_fexp, b_fact;
   logic [2:0]  b_fptr;

   logic        c_sv, c_done, c_abort, c_miss, c_fev;
   logic [15:0] c_err, c_bcnt, c_fexp, c_fact;
   logic [1:0]  c_fptr;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt;
   int done_at;
   int miss_cnt;
   logic [2:0] prev_ptr;

   ring_buffer_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(16), .DDR_MODE(1)) u_a (
      .clk(clk), .reset(reset), .clear(clear), .listen(listen), .strobe(strobe),
      .din(din), .readPtr(rd_ptr), .dout(dout),
      .shadow_valid(a_sv), .burst_done(a_done), .abort(a_abort), .mismatch(a_miss),
      .err_count(a_err), .burst_count(a_bcnt), .first_err_valid(a_fev),
      .first_err_ptr(a_fptr), .first_err_exp(a_fexp), .first_err_act(a_fact));

   ring_buffer_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(4), .DDR_MODE(1)) u_b (
      .clk(clk), .reset(reset), .clear(clear), .listen(listen), .strobe(strobe),
      .din(din), .readPtr(rd_ptr), .dout(dout),
      .shadow_valid(b_sv), .burst_done(b_done), .abort(b_abort), .mismatch(b_miss),
      .err_count(b_err), .burst_count(b_bcnt), .first_err_valid(b_fev),
      .first_err_ptr(b_fptr), .first_err_exp(b_fexp), .first_err_act(b_fact));

   ring_buffer_checker #(.DATA_W(16), .DEPTH(4), .CNT_W(16), .DDR_MODE(0)) u_c (
      .clk(clk), .reset(reset), .clear(clear), .listen(c_listen), .strobe(c_strobe),
      .din(c_din), .readPtr(c_ptr), .dout(dout),
      .shadow_valid(c_sv), .burst_done(c_done), .abort(c_abort), .mismatch(c_miss),
      .err_count(c_err), .burst_count(c_bcnt), .first_err_valid(c_fev),
      .first_err_ptr(c_fptr), .first_err_exp(c_fexp), .first_err_act(c_fact));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one comparison: count it, report a difference
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; listen = 1'b0; strobe = 1'b0;
      din = '0; rd_ptr = '0; dout = '0;
      c_listen = 1'b0; c_strobe = 1'b0; c_din = '0; c_ptr = '0;
      tick(); tick();

      // reset state
      check_val("rst_sv",   32'(a_sv),   32'h0);
      check_val("rst_err",  32'(a_err),  32'h0);
      check_val("rst_bcnt", 32'(a_bcnt), 32'h0);
      check_val("rst_fev",  32'(a_fev),  32'h0);
      check_val("rst_c_sv", 32'(c_sv),   32'h0);
      reset = 1'b1;
      tick();

      // DDR burst of 8 beats, data 1000..1007
      listen = 1'b1;
      tick();
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         din    = 16'h1000 + 16'(i);
         strobe = ~strobe;
         tick();
         done_cnt += int'(a_done);
      end
      tick();
      done_cnt += int'(a_done);
      check_val("burst_done_cnt", 32'(done_cnt), 32'd1);
      check_val("burst_count",    32'(a_bcnt),   32'd1);
      check_val("burst_sv",       32'(a_sv),     32'h1);
      check_val("burst_count_b",  32'(b_bcnt),   32'd1);

      // clean read-back 1..7 then wrap to 0; dout lags the pointer by one cycle
      miss_cnt = 0;
      prev_ptr = 3'd0;
      for (int p = 1; p <= 8; p++) begin
         rd_ptr   = 3'(p);
         dout     = 16'h1000 + 16'(prev_ptr);
         tick();
         miss_cnt += int'(a_miss);
         prev_ptr = 3'(p);
      end
      dout = 16'h1000 + 16'(prev_ptr);
      tick();
      miss_cnt += int'(a_miss);
      tick();
      miss_cnt += int'(a_miss);
      check_val("clean_miss", 32'(miss_cnt), 32'd0);
      check_val("clean_err",  32'(a_err),    32'd0);

      // corrupted read at ptr 5
      rd_ptr = 3'd5;
      tick();
      check_val("corr_miss_early", 32'(a_miss), 32'h0);
      dout = 16'hDEAD;
      tick();
      check_val("corr_miss", 32'(a_miss), 32'h1);
      check_val("corr_err",  32'(a_err),  32'd1);
      check_val("corr_fev",  32'(a_fev),  32'h1);
      check_val("corr_fptr", 32'(a_fptr), 32'd5);
      check_val("corr_fexp", 32'(a_fexp), 32'h1005);
      check_val("corr_fact", 32'(a_fact), 32'hDEAD);
      tick();
      check_val("corr_miss_pulse", 32'(a_miss), 32'h0);

      // second mismatch at ptr 2 leaves the first-error capture alone
      rd_ptr = 3'd2;
      tick();
      dout = 16'hBEEF;
      tick();
      check_val("corr2_err",  32'(a_err),  32'd2);
      check_val("corr2_fptr", 32'(a_fptr), 32'd5);
      check_val("corr2_fact", 32'(a_fact), 32'hDEAD);

      // abort after 3 beats of a new burst
      for (int i = 0; i < 3; i++) begin
         din    = 16'h2000 + 16'(i);
         strobe = ~strobe;
         tick();
      end
      check_val("abort_sv_cap", 32'(a_sv), 32'h0);
      listen = 1'b0;
      tick();
      check_val("abort_pulse", 32'(a_abort), 32'h1);
      check_val("abort_sv",    32'(a_sv),    32'h0);
      check_val("abort_bcnt",  32'(a_bcnt),  32'd1);
      tick();
      check_val("abort_pulse_end", 32'(a_abort), 32'h0);
      rd_ptr = 3'd6;
      tick();
      dout = 16'h0000;
      tick();
      tick();
      check_val("abort_nocheck_err",  32'(a_err),  32'd2);
      check_val("abort_nocheck_miss", 32'(a_miss), 32'h0);

      // fresh burst 3000..3007 then 20 forced mismatches
      listen = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         din    = 16'h3000 + 16'(i);
         strobe = ~strobe;
         tick();
      end
      tick();
      check_val("burst2_bcnt", 32'(a_bcnt), 32'd2);
      dout = 16'hFFFF;
      for (int i = 0; i < 20; i++) begin
         rd_ptr = (i % 2 == 0) ? 3'd0 : 3'd1;
         tick();
      end
      tick();
      check_val("sat_err_a",  32'(a_err),  32'd22);
      check_val("sat_err_b",  32'(b_err),  32'hF);
      check_val("sat_fptr_a", 32'(a_fptr), 32'd5);

      // clear coinciding with a mismatch
      rd_ptr = 3'd3;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_val("clr_err_a",  32'(a_err),  32'd0);
      check_val("clr_err_b",  32'(b_err),  32'd0);
      check_val("clr_fev_a",  32'(a_fev),  32'h0);
      check_val("clr_bcnt_a", 32'(a_bcnt), 32'd0);
      check_val("clr_sv_a",   32'(a_sv),   32'h1);

      // SDR, DEPTH 4: only rising strobe edges are beats
      c_listen = 1'b1;
      tick();
      done_cnt = 0;
      done_at  = -1;
      for (int k = 0; k < 7; k++) begin
         c_strobe = ~c_strobe;
         c_din    = 16'h4000 + 16'(k);
         tick();
         if (c_done) begin
            done_cnt++;
            done_at = k;
         end
         if (k == 5) check_val("sdr_bcnt_early", 32'(c_bcnt), 32'd0);
      end
      tick();
      check_val("sdr_done_cnt", 32'(done_cnt), 32'd1);
      check_val("sdr_done_at",  32'(done_at),  32'd6);
      check_val("sdr_bcnt",     32'(c_bcnt),   32'd1);
      check_val("sdr_sv",       32'(c_sv),     32'h1);
      c_ptr = 2'd2;
      tick();
      dout = 16'h4004;
      tick();
      check_val("sdr_good_miss", 32'(c_miss), 32'h0);
      c_ptr = 2'd1;
      tick();
      dout = 16'h4000;
      tick();
      check_val("sdr_bad_miss", 32'(c_miss), 32'h1);
      check_val("sdr_bad_err",  32'(c_err),  32'd1);
      check_val("sdr_bad_fexp", 32'(c_fexp), 32'h4002);

      // reset in the middle of a burst after 2 beats
      c_strobe = 1'b0; tick();
      c_strobe = 1'b1; tick();
      c_strobe = 1'b0; tick();
      c_strobe = 1'b1; tick();
      check_val("mid_sv_pre", 32'(c_sv), 32'h0);
      reset = 1'b0;
      #1;
      check_val("mid_rst_bcnt",  32'(c_bcnt),  32'd0);
      check_val("mid_rst_err",   32'(c_err),   32'd0);
      check_val("mid_rst_fev",   32'(c_fev),   32'h0);
      check_val("mid_rst_abort", 32'(c_abort), 32'h0);
      check_val("mid_rst_a_sv",  32'(a_sv),    32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("mid_rst_abort_hold", 32'(c_abort), 32'h0);
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("post_rst_abort", 32'(c_abort), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
